// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (transmitter and receiver).
//   rx_state_t        : receiver FSM state encoding
//   SERIAL_START_BIT  : line level of a start bit
//   SERIAL_IDLE_LEVEL : line level while idle
//   SERIAL_W          : default data bits per frame
package serial_pkg;

  // state  | meaning
  // IDLE   | waiting for a start bit on a strobe
  // DATA   | shifting in data bits
  // PARITY | waiting for the parity bit (parity build only)
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

  localparam logic SERIAL_START_BIT  = 1'b0;
  localparam logic SERIAL_IDLE_LEVEL = 1'b1;
  localparam int   SERIAL_W          = 8;

endpackage

// File: rtl/serial_parallel_rx_if.sv
// Bundle of the receiver's line, control and output handshake signals.
//   master : drives en/bit_stb/din/ready, observes the received word
//   slave  : the receiver itself
interface serial_parallel_rx_if #(
  parameter int W = serial_pkg::SERIAL_W
);
  logic         en;
  logic         bit_stb;
  logic         din;
  logic         ready;
  logic [W-1:0] data_o;
  logic         valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  modport master (
    output en, bit_stb, din, ready,
    input  data_o, valid, busy, overrun, parity_err
  );

  modport slave (
    input  en, bit_stb, din, ready,
    output data_o, valid, busy, overrun, parity_err
  );
endinterface

// File: rtl/serial_shift_core.sv
// W-bit receive shift register with bit counter.
//   clk, rst  : clock, async active-low reset
//   clear     : zero the register and bit_cnt (has priority over shift)
//   shift     : insert din and count one bit
//   din       : serial data bit
//   word_nxt  : register contents after this cycle (includes the bit
//               being inserted when shift is high)
//   last_bit  : this shift makes bit_cnt reach W
// W must be at least 2.
module serial_shift_core #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         shift,
  input  logic         din,
  output logic [W-1:0] word_nxt,
  output logic         last_bit
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  shreg;
  logic [CW-1:0] bit_cnt;
  logic [W-1:0]  inserted;

  always_comb begin
    inserted = shreg;
    if (MSB_FIRST)
      inserted = {shreg[W-2:0], din};   // first bit ends up in [W-1]
    else
      inserted = {din, shreg[W-1:1]};   // first bit ends up in [0]
    word_nxt = shift ? inserted : shreg;
    last_bit = shift && (bit_cnt == CW'(W - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      shreg   <= inserted;
      bit_cnt <= bit_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/serial_parallel_rx.sv
// Serial-to-parallel receiver: frames a start bit plus W data bits sampled
// on bit strobes and presents the word on a registered valid/ready slot
// with sticky overrun detection.
//   clk, rst   : clock, async active-low reset
//   bus.en     : enable; low aborts the frame (output slot untouched)
//   bus.bit_stb, bus.din : bit strobe and serial line
//   bus.data_o, bus.valid, bus.ready : output word handshake
//   bus.busy   : FSM not in IDLE
//   bus.overrun: sticky, a completed word was dropped
//   bus.parity_err : parity mismatch of data_o (0 without parity)
// Optional feature: define SERIAL_RX_PARITY_EN to expect an even-parity
// bit after the data bits.
module serial_parallel_rx
  import serial_pkg::*;
#(
  parameter int W         = SERIAL_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_parallel_rx_if.slave  bus
);
  rx_state_t    state;
  logic         shift;
  logic         clear;
  logic         last_bit;
  logic         done;
  logic         stb;
  logic [W-1:0] word_nxt;

  serial_shift_core #(.W(W), .MSB_FIRST(MSB_FIRST)) u_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .shift    (shift),
    .din      (bus.din),
    .word_nxt (word_nxt),
    .last_bit (last_bit)
  );

  always_comb begin
    stb   = bus.en & bus.bit_stb;
    shift = stb & (state == DATA);
    clear = ~bus.en | (state == IDLE);
`ifdef SERIAL_RX_PARITY_EN
    done  = stb & (state == PARITY);
`else
    done  = last_bit;
`endif
  end

`ifdef SERIAL_RX_PARITY_EN
  logic parity_err_q;
  // In PARITY the register is not shifting, so word_nxt is the full word
  // and din carries the parity bit.
  logic parity_calc;
  assign parity_calc    = (^word_nxt) ^ bus.din;
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bus.busy    <= 1'b0;
      bus.data_o  <= '0;
      bus.valid   <= 1'b0;
      bus.overrun <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (stb && bus.din == SERIAL_START_BIT) begin
            state    <= DATA;
            bus.busy <= 1'b1;
          end
        end
        DATA: begin
          if (last_bit) begin
`ifdef SERIAL_RX_PARITY_EN
            state    <= PARITY;
`else
            state    <= IDLE;
            bus.busy <= 1'b0;
`endif
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (stb) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
`endif
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase

      if (!bus.en) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
      end

      // A slot being emptied by a handshake this cycle counts as free.
      if (done) begin
        if (!bus.valid || bus.ready) begin
          bus.data_o <= word_nxt;
          bus.valid  <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          parity_err_q <= parity_calc;
`endif
          if (bus.valid)
            bus.overrun <= 1'b0;
        end else begin
          bus.overrun <= 1'b1;
        end
      end else if (bus.valid && bus.ready) begin
        bus.valid   <= 1'b0;
        bus.overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_parallel_rx.sv
// Directed self-checking bench for serial_parallel_rx (W=8, MSB first).
module tb_serial_parallel_rx;
  import serial_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  serial_parallel_rx_if #(.W(8)) bus ();

  serial_parallel_rx #(.W(8), .MSB_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the falling edge
  // before anything is changed.
  task automatic send_bit(input logic b);
    bus.bit_stb = 1'b1;
    bus.din     = b;
    @(negedge clk);
    bus.bit_stb = 1'b0;
    bus.din     = SERIAL_IDLE_LEVEL;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par,
                            input bit rdy_last, input bit chk_busy);
    send_bit(SERIAL_START_BIT);
    if (chk_busy) chk("busy_in_frame", {31'd0, bus.busy}, 32'd1);
    for (int i = 7; i >= 1; i--) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
    send_bit(d[0]);
    if (rdy_last) bus.ready = 1'b1;
    send_bit(par);
`else
    if (rdy_last) bus.ready = 1'b1;
    send_bit(d[0]);
    if (par) ; // parity bit unused in this build
`endif
    if (rdy_last) bus.ready = 1'b0;
  endtask

  task automatic pulse_ready();
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_err       = 0;
    rst         = 1'b0;
    bus.en      = 1'b1;
    bus.bit_stb = 1'b0;
    bus.din     = SERIAL_IDLE_LEVEL;
    bus.ready   = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_valid",   {31'd0, bus.valid},   32'd0);
    chk("rst_busy",    {31'd0, bus.busy},    32'd0);
    chk("rst_data",    {24'd0, bus.data_o},  32'd0);
    chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    chk("rst_perr",    {31'd0, bus.parity_err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of a frame (start + 3 data bits of 0xA5).
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("mid_busy_pre", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'd0, bus.busy},  32'd0);
    chk("mid_rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("mid_rst_data",  {24'd0, bus.data_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic receive with ready held high.
    bus.ready = 1'b1;
    chk("basic_busy_before", {31'd0, bus.busy}, 32'd0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    chk("basic_valid", {31'd0, bus.valid},  32'd1);
    chk("basic_data",  {24'd0, bus.data_o}, 32'h0A5);
    chk("basic_busy_after", {31'd0, bus.busy}, 32'd0);
    chk("basic_perr",  {31'd0, bus.parity_err}, 32'd0);
    @(negedge clk);
    chk("basic_valid_1cyc", {31'd0, bus.valid},  32'd0);
    chk("basic_data_hold",  {24'd0, bus.data_o}, 32'h0A5);
    bus.ready = 1'b0;

    // Idle noise: strobes with the line high.
    send_bit(1'b1);
    send_bit(1'b1);
    chk("noise_busy",  {31'd0, bus.busy},  32'd0);
    send_bit(1'b1);
    chk("noise_busy2", {31'd0, bus.busy},  32'd0);
    chk("noise_valid", {31'd0, bus.valid}, 32'd0);

    // Overrun: two back-to-back words with nobody accepting.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("ovr_first_valid", {31'd0, bus.valid},  32'd1);
    chk("ovr_first_data",  {24'd0, bus.data_o}, 32'h03C);
    chk("ovr_first_flag",  {31'd0, bus.overrun}, 32'd0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    chk("ovr_data",    {24'd0, bus.data_o},  32'h03C);
    chk("ovr_valid",   {31'd0, bus.valid},   32'd1);
    chk("ovr_flag",    {31'd0, bus.overrun}, 32'd1);
    pulse_ready();
    chk("ovr_clr_valid", {31'd0, bus.valid},   32'd0);
    chk("ovr_clr_flag",  {31'd0, bus.overrun}, 32'd0);

    // Completion coinciding with an accepted handshake.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("sim_first_valid", {31'd0, bus.valid}, 32'd1);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    chk("sim_data",    {24'd0, bus.data_o},  32'h05A);
    chk("sim_valid",   {31'd0, bus.valid},   32'd1);
    chk("sim_overrun", {31'd0, bus.overrun}, 32'd0);
    pulse_ready();
    chk("sim_drain_valid", {31'd0, bus.valid}, 32'd0);

    // Abort after 4 data bits, then a clean frame.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
    bus.en = 1'b0;
    @(negedge clk);
    chk("abort_busy",  {31'd0, bus.busy},  32'd0);
    chk("abort_valid", {31'd0, bus.valid}, 32'd0);
    chk("abort_data",  {24'd0, bus.data_o}, 32'h05A);
    bus.en = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    chk("abort_idle", {31'd0, bus.busy}, 32'd0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    chk("after_abort_data",  {24'd0, bus.data_o}, 32'h081);
    chk("after_abort_valid", {31'd0, bus.valid},  32'd1);
    pulse_ready();

`ifdef SERIAL_RX_PARITY_EN
    send_frame(8'h01, 1'b0, 1'b0, 1'b0);
    chk("par_bad",  {31'd0, bus.parity_err}, 32'd1);
    chk("par_bad_valid", {31'd0, bus.valid}, 32'd1);
    pulse_ready();
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    chk("par_good", {31'd0, bus.parity_err}, 32'd0);
    pulse_ready();
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/serial_parallel_rx.md
# serial_parallel_rx

Serial-to-parallel receiver: the receive end of the one-bit serial link driven by our parallel-to-serial transmitter. It samples `din` on single-cycle bit strobes, which typically come from the debounced key pulse or a bit-rate tick. It frames each word by a start bit, assembles `W` data bits, and presents the word on a registered valid/ready output with overrun detection. It sits between the serial line and any byte consumer, such as a display or register file.

## Interface
- `W`, default 8: data bits per frame.
- `MSB_FIRST`, default 1: 1 means the first data bit received lands in `data_o[W-1]`; 0 means it lands in `data_o[0]`.

- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: receiver enable; low aborts any frame and holds the FSM in IDLE.
- `bit_stb` in 1: bit strobe; each cycle it is high, `din` is sampled once.
- `din` in 1: serial data line; idles high.
- `data_o` out W: received word, stable while `valid` is high.
- `valid` out 1: word available.
- `ready` in 1: consumer accepts the word when `valid & ready` are both high.
- `busy` out 1: FSM is not in IDLE.
- `overrun` out 1: sticky; a completed word was dropped.
- `parity_err` out 1: parity mismatch for the current `data_o`; constant 0 without the parity feature.

## Operation
- Frame on the line: start bit (0), then W data bits, then an even-parity bit when `SERIAL_RX_PARITY_EN` is defined. Only cycles with `bit_stb` high count as bits.
- FSM states are IDLE, DATA, PARITY (exists only with the macro), and DONE. The DONE step happens within the final-bit edge, not as a separate cycle.
- IDLE:
  - `bit_stb & en & ~din`: go to DATA, clear `bit_cnt`.
  - `din`=1 on a strobe: ignored, stay in IDLE.
- DATA:
  - Each strobe shifts `din` into the shift register and increments `bit_cnt` (width `$clog2(W+1)`).
  - On the strobe carrying bit W: go to PARITY if the macro is defined, otherwise complete.
- PARITY: on the next strobe, capture the parity bit, then complete.
- Complete:
  - Return to IDLE.
  - If the output slot is free, or is being freed by `valid & ready` in this same cycle: load `data_o`, set `valid`=1, load `parity_err`.
  - Otherwise: keep the old `data_o`, drop the new word, set `overrun`=1.
- Handshake:
  - `valid & ready` with no completion in that cycle: `valid` goes to 0.
  - `data_o` holds its value after the handshake.
  - `overrun` clears only on reset or on an accepted handshake.
- `en` low at any time: return to IDLE immediately and discard the partial word. `valid`, `data_o`, and `overrun` are unaffected.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, `data_o`=0, `valid`=0, `busy`=0, `overrun`=0, `parity_err`=0, shift register 0, `bit_cnt`=0.
- All outputs are registered; there are no combinational paths from input to output.
- Latency:
  - The clock edge that samples the final strobe (data bit W, or the parity bit) sets `valid`.
  - `valid` is visible in the following cycle.
  - `busy` falls on that same edge.
- Minimum frame length: 1+W strobes (2+W with parity). Back-to-back strobes in consecutive cycles are legal and each counts as one bit.
- A start bit may be accepted in the cycle right after completion; no idle gap is required.
- Completion and `valid & ready` in the same cycle: the new word loads, `valid` stays 1, and `overrun` is not set.
- `ready` is ignored while `valid`=0.

## Configuration
- Macro: `SERIAL_RX_PARITY_EN`.
- Defined:
  - The PARITY state exists and frames are W+2 strobes.
  - `parity_err` = XOR of all data bits and the parity bit, registered alongside `data_o`.
  - A word with a parity error is still delivered with `valid`.
- Undefined:
  - No PARITY state; frames are W+1 strobes.
  - `parity_err` is tied to 0.
  - The port list is unchanged.

## Structure
- Shared package `serial_pkg` holds:
  - the state enum `rx_state_t` (IDLE, DATA, PARITY);
  - the constants `SERIAL_START_BIT`=0 and `SERIAL_IDLE_LEVEL`=1;
  - the default word width `SERIAL_W`=8.
- The transmitter uses the same package constants.
- One sub-module, `serial_shift_core`, contains the W-bit shift register plus `bit_cnt`, with the `MSB_FIRST` insertion logic. It reports `last_bit` when `bit_cnt` reaches W.
- FSM, output slot, handshake, and overrun logic live in the top module.

## Test plan
- Reset mid-frame: after 3 data strobes assert `rst`=0 -> all outputs 0, state IDLE; the next full 0xA5 frame is received correctly.
- Basic receive, `MSB_FIRST`=1, `ready`=1: strobe 0, then 1,0,1,0,0,1,0,1 -> `data_o`=0xA5, `valid` for 1 cycle starting the cycle after the last strobe, `busy` high for exactly that frame.
- Idle noise: strobes with `din`=1 while in IDLE -> `busy` stays 0, no `valid`.
- Overrun: hold `ready`=0, send 0x3C then 0xC3 -> `data_o`=0x3C, `valid`=1, `overrun`=1. Pulse `ready` -> `valid`=0, `overrun`=0.
- Simultaneous events: assert `ready` in the completion cycle of the second word -> `data_o`=second word, `valid` stays 1, `overrun`=0.
- Abort: drop `en` after 4 data bits -> IDLE, no `valid`. With `SERIAL_RX_PARITY_EN`: 0x01 with parity bit 0 -> `parity_err`=1; with parity bit 1 -> `parity_err`=0.
